// File: rtl/multdiv.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (restoring on magnitudes).
// One add/subtract step per clock for STEPS cycles, then a finish cycle registers the outputs.
module multdiv #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CW = 6;

  state_t          state;
  logic [CW-1:0]   count;
  // hi/lo form the accumulator: Booth {hi,lo} product, or {remainder, quotient} for divide.
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic             booth_q;
  logic [WIDTH-1:0] opnd;
  logic             neg;
  logic             dz;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   a_ext, booth_sum, mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [2*WIDTH-1:0] product;
  logic             mul_ovf;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem, div_quo, quotient;

  assign state_dbg = state;

  always_comb begin
    a_mag = operand_a[WIDTH-1] ? ({WIDTH{1'b0}} - operand_a) : operand_a;
    b_mag = operand_b[WIDTH-1] ? ({WIDTH{1'b0}} - operand_b) : operand_b;

    a_ext     = {opnd[WIDTH-1], opnd};
    booth_sum = hi;
    case ({lo[0], booth_q})
      2'b01:   booth_sum = hi + a_ext;
      2'b10:   booth_sum = hi - a_ext;
      default: booth_sum = hi;
    endcase
    mul_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_lo  = {booth_sum[0], lo[WIDTH-1:1]};
    product = {hi[WIDTH-1:0], lo};
    // Overflow when the product does not fit in WIDTH signed bits.
    mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

    div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo   = {lo[WIDTH-2:0], div_ge};
    quotient  = neg ? ({WIDTH{1'b0}} - lo) : lo;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      booth_q    <= 1'b0;
      opnd       <= '0;
      neg        <= 1'b0;
      dz         <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (ctrl_mult && ctrl_div) begin
            state <= IDLE;
          end else if (ctrl_mult) begin
            state   <= MUL;
            busy    <= 1'b1;
            count   <= '0;
            opnd    <= operand_a;
            hi      <= '0;
            lo      <= operand_b;
            booth_q <= 1'b0;
          end else if (ctrl_div) begin
            state <= DIV;
            busy  <= 1'b1;
            count <= '0;
            opnd  <= b_mag;
            hi    <= '0;
            lo    <= a_mag;
            neg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            dz    <= (operand_b == '0);
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (count == CW'(STEPS)) begin
            result     <= product[WIDTH-1:0];
            exception  <= mul_ovf;
            result_rdy <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            hi      <= mul_hi;
            lo      <= mul_lo;
            booth_q <= lo[0];
            count   <= count + 6'd1;
          end
        end
        DIV: begin
          if (count == CW'(STEPS)) begin
            // Divide-by-zero still runs the full latency; its quotient is forced to zero.
            result     <= dz ? '0 : quotient;
            exception  <= dz;
            result_rdy <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            hi    <= {1'b0, div_rem};
            lo    <= div_quo;
            count <= count + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: the driver pushes expected {exception,result} and start cycle,
// a monitor pops and compares on every result_rdy pulse.
module tb_multdiv;

  logic        clk;
  logic        resetn;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;
  logic [1:0]  state_dbg;

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          cyc;
  int          tests;
  int          fails;

  multdiv dut (
    .clock      (clk),
    .resetn     (resetn),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result_rdy pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && result_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got result_rdy=1 expected 0 (t=%0t)", $time);
      end else begin
        logic [32:0] e;
        int          s;
        e = exp_q.pop_front();
        s = lat_q.pop_front();
        check("result", 64'(result), 64'(e[31:0]));
        check("exception", 64'(exception), 64'(e[32]));
        check("latency", 64'(cyc - s), 64'd33);
        check("busy_at_rdy", 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge; the start is sampled at the following posedge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic exc, input logic [31:0] res, input bit push);
    ctrl_mult = m;
    ctrl_div  = d;
    operand_a = a;
    operand_b = b;
    if (push) begin
      exp_q.push_back({exc, res});
      lat_q.push_back(cyc + 1);
    end
    @(negedge clk);
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic m, input logic [31:0] a, input logic [31:0] b,
                     input logic exc, input logic [31:0] res);
    issue(m, !m, a, b, exc, res, 1'b1);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_empty();
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    tests     = 0;
    fails     = 0;
    resetn    = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_exception", 64'(exception), 64'd0);
    check("reset_rdy", 64'(result_rdy), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Multiplies
    run(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB);
    run(1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE);
    run(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0000);
    run(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, 32'h0000_001E);
    run(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000);

    // Divides
    run(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD);
    run(1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2);
    run(1'b0, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000);
    run(1'b0, 32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0000_0001);
    run(1'b0, 32'h0000_0000, 32'hFFFF_FFFD, 1'b0, 32'h0000_0000);
    run(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000);

    // ctrl_div pulsed at E10 of a multiply is ignored
    issue(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 1'b0, 32'h0001_2340, 1'b1);
    repeat (9) @(negedge clk);
    issue(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    check("busy_ignored_start", 64'(busy), 64'd1);
    wait_empty();

    // Both starts high in IDLE: nothing starts
    held = result;
    issue(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
    check("both_busy", 64'(busy), 64'd0);
    check("both_state", 64'(state_dbg), 64'd0);
    repeat (40) @(negedge clk);
    check("both_result_held", 64'(result), 64'(held));

    // Reset at E15 of a divide
    issue(1'b0, 1'b1, 32'h0000_03E8, 32'h0000_0003, 1'b0, 32'h0000_014D, 1'b1);
    repeat (15) @(posedge clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_exception", 64'(exception), 64'd0);
    check("abort_rdy", 64'(result_rdy), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    run(1'b1, 32'h0000_000C, 32'h0000_000C, 1'b0, 32'h0000_0090);

    // Back-to-back: second start sampled at E34 while in DONE
    issue(1'b1, 1'b0, 32'h0000_0009, 32'h0000_0009, 1'b0, 32'h0000_0051, 1'b1);
    n = 0;
    while (!result_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_rdy", 64'(result_rdy), 64'd1);
    issue(1'b0, 1'b1, 32'h0000_0051, 32'hFFFF_FFF7, 1'b0, 32'hFFFF_FFF7, 1'b1);
    check("b2b_busy", 64'(busy), 64'd1);
    repeat (20) @(negedge clk);
    check("b2b_result_held", 64'(result), 64'h0000_0051);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
